// File: rtl/apb_requester.sv
// apb_requester: APB initiator for the GPIO subsystem.
// Accepts one read/write command at a time over a valid/ready port and runs it
// through the APB SETUP/ACCESS handshake. Each accepted command produces exactly
// one rsp_valid pulse. An ACCESS phase that stalls on pready for TIMEOUT
// consecutive cycles is aborted and reported as a timeout error.
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // Stall counter only needs to reach TIMEOUT-1; a zero TIMEOUT disables the abort.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic             TO_EN    = (TIMEOUT != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_e;

    state_e            state_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              cmd_ready_s;
    logic              accept_s;
    logic              stall_limit_s;

    // Command port is ready while idle, or in the ACCESS cycle that completes.
    always_comb begin
        cmd_ready_s = 1'b0;
        case (state_q)
            ST_IDLE:   cmd_ready_s = 1'b1;
            ST_ACCESS: cmd_ready_s = pready;
            default:   cmd_ready_s = 1'b0;
        endcase
    end

    // Handshake and stall-limit qualifiers used by the FSM.
    always_comb begin
        accept_s      = cmd_valid & cmd_ready_s;
        stall_limit_s = TO_EN & (cnt_q == CNT_LAST);
    end

    // Transfer FSM: sequences APB phases and registers every bus and response output.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= {ADDR_W{1'b0}};
            pwdata_q      <= {DATA_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_W{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q   <= ST_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= cmd_addr;
                        pwrite_q  <= cmd_write;
                        pwdata_q  <= cmd_wdata;
                        cnt_q     <= {CNT_W{1'b0}};
                    end else begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    psel_q    <= 1'b1;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        // Completion takes priority over a coincident stall limit.
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? {DATA_W{1'b0}} : prdata;
                        if (accept_s) begin
                            // Back-to-back: psel stays high, penable drops for the new SETUP.
                            state_q   <= ST_SETUP;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            paddr_q   <= cmd_addr;
                            pwrite_q  <= cmd_write;
                            pwdata_q  <= cmd_wdata;
                            cnt_q     <= {CNT_W{1'b0}};
                        end else begin
                            state_q   <= ST_IDLE;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                        end
                    end else if (stall_limit_s) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= {DATA_W{1'b0}};
                        state_q       <= ST_IDLE;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
